rom_seq_ctrl: RTL and testbench
===============================

Name: rom_seq_ctrl

Overview:
- Sequencer that owns the clock divider's enable (on_i) and steps a ROM address through a programmable range.
- Each rising edge of the divided clock in RUN mode, or each step press in PAUSE mode, advances the address.
- Sits between the board switches/buttons, the clock divider and the ROM address port in the lab top level.
- All logic is in the system clock domain; the divided clock is treated as data, never as a clock.

Parameters:
- AW, 8, ROM address width.
- DB_CYCLES, 16'd50000, step-button debounce length in clk cycles (used only with STEP_DEBOUNCE_EN).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- run_i  input  1  level: 1 = free-run, 0 = pause.
- step_i  input  1  single-step button, active high.
- clr_i  input  1  synchronous return to IDLE.
- loop_i  input  1  1 = wrap at end of range, 0 = stop at end.
- start_addr_i  input  AW  first address of the range.
- end_addr_i  input  AW  last address of the range.
- div_tick_i  input  1  divided clock from the divider (clk_o); same domain, registered source.
- div_on_o  output  1  drives the divider's on_i.
- addr_o  output  AW  ROM address.
- addr_vld_o  output  1  one-cycle pulse whenever addr_o takes a new value.
- busy_o  output  1  high in RUN and PAUSE.
- done_o  output  1  high in DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, on rst_n.
- Reset values: state=IDLE; addr_o=0; div_on_o=0; addr_vld_o=0; busy_o=0; done_o=0; all edge-detect and debounce registers=0.
- Edge detection:
  - tick_q <= div_tick_i.
  - tick_rise = div_tick_i & ~tick_q.
  - step_rise is the rising edge of step_i, taken after debounce when STEP_DEBOUNCE_EN is defined.
- States: IDLE, RUN, PAUSE, DONE.
- IDLE:
  - Latches start_r <= start_addr_i and end_r <= end_addr_i on exit.
  - run_i=1: addr_o <= start_addr_i, addr_vld_o pulses, goes to RUN.
  - Otherwise, step_rise: same load, goes to PAUSE.
  - run_i takes priority over step_rise.
- RUN:
  - div_on_o=1 (registered, so asserted from the first RUN cycle).
  - tick_rise performs ADVANCE.
  - run_i=0 goes to PAUSE. div_on_o drops, and the divider clears, so the first tick after resuming comes a full divider period later.
- PAUSE:
  - div_on_o=0.
  - step_rise performs ADVANCE.
  - run_i=1 goes to RUN.
- ADVANCE:
  - If addr_o != end_r: addr_o <= addr_o+1, which wraps modulo 2^AW. Consequently start_r > end_r is legal and runs through the 2^AW boundary.
  - If addr_o == end_r and loop_i=1: addr_o <= start_r.
  - If addr_o == end_r and loop_i=0: addr_o holds, no addr_vld_o pulse, go to DONE.
  - Latency: addr_o and addr_vld_o change on the clk edge following the cycle in which tick_rise or step_rise is true.
- DONE:
  - done_o=1, div_on_o=0, busy_o=0.
  - addr_o holds the last address.
  - Exits only on clr_i.
- clr_i:
  - Overrides everything; from any state, the next cycle is IDLE with div_on_o=0.
  - addr_o holds its value; done_o clears.
- Simultaneous events:
  - Advance and mode change in the same cycle: the advance is taken and the state changes.
  - Example: tick_rise with run_i=0 in RUN gives a new addr_o and the state becomes PAUSE.
  - start==end: exactly one address is issued, then DONE or the same address repeats if looping.
- Mid-run changes: start_addr_i and end_addr_i changes after IDLE exit are ignored until the next IDLE.
- Reset mid-operation: everything returns immediately to the reset values; the divider is stopped through div_on_o=0.

Optional Feature:
- Macro: STEP_DEBOUNCE_EN.
- Defined:
  - step_i passes through a 2-flop synchronizer.
  - The level is accepted only after it is stable for DB_CYCLES consecutive cycles.
  - step_rise is generated from the debounced level, adding DB_CYCLES+2 cycles of latency.
- Undefined: step_i is registered once, and step_rise = step_i & ~step_q.

Decomposition:
- Package rom_seq_pkg:
  - State encoding: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3.
  - Default AW and DB_CYCLES.
- Sub-module btn_debounce:
  - Synchronizer, stability counter and rising-edge output.
  - Instantiated only under STEP_DEBOUNCE_EN.

Test Plan:
- Bench divider model toggles div_tick_i every 4 cycles while div_on_o=1. Set AW=8, start=3, end=5, loop=0, run_i=1 -> addr_o 3,4,5 with one addr_vld_o pulse each, 8 cycles apart; then done_o=1, div_on_o=0, addr_o=5.
- Same setup with loop=1 -> sequence 3,4,5,3,4 with no DONE; busy_o stays 1.
- run_i=0 with three step_i pulses, start=0xFE, end=0x01 -> addr_o 0xFE, 0xFF, 0x00; one further step -> 0x01.
- In RUN, drop run_i in the same cycle as tick_rise -> addr_o increments once, state is PAUSE, div_on_o=0 next cycle.
- Pulse clr_i in RUN at addr_o=4 -> IDLE next cycle with busy_o=0 and addr_o=4. Assert rst_n=0 asynchronously mid-RUN -> all outputs 0 immediately.
- With STEP_DEBOUNCE_EN and DB_CYCLES=10: a 5-cycle step glitch produces no advance; a 20-cycle press produces exactly one advance, 12 cycles after the press.

Source files
------------

// File: rtl/rom_seq_pkg.sv
// Shared types and defaults for the ROM address sequencer.
// DEF_DB_CYCLES exists only when STEP_DEBOUNCE_EN is defined.
package rom_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEF_AW = 8;

`ifdef STEP_DEBOUNCE_EN
  localparam logic [15:0] DEF_DB_CYCLES = 16'd50000;
`endif

endpackage

// File: rtl/rom_seq_ctrl_btn_debounce.sv
// Step-button conditioner: 2-flop synchronizer, stability counter, rising-edge pulse.
// Compiled only when STEP_DEBOUNCE_EN is defined.
`ifdef STEP_DEBOUNCE_EN
module btn_debounce
  import rom_seq_pkg::*;
#(
  parameter logic [15:0] DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_rise
);

  logic        r_sync1;
  logic        r_sync2;
  logic [15:0] r_cnt;
  logic        r_level;
  logic        r_level_q;

  // The accepted level follows the synchronized input only after it has
  // differed from the current level for DB_CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_cnt     <= 16'd0;
      r_level   <= 1'b0;
      r_level_q <= 1'b0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_level_q <= r_level;
      if (r_sync2 == r_level) begin
        r_cnt <= 16'd0;
      end else if (r_cnt == DB_CYCLES - 16'd1) begin
        r_level <= r_sync2;
        r_cnt   <= 16'd0;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign o_rise = r_level & ~r_level_q;

endmodule
`endif

// File: rtl/rom_seq_ctrl.sv
// ROM address sequencer: owns the divider enable and steps an address range.
// STEP_DEBOUNCE_EN inserts btn_debounce on the step button.
module rom_seq_ctrl
  import rom_seq_pkg::*;
#(
  parameter int AW = DEF_AW
`ifdef STEP_DEBOUNCE_EN
  ,
  parameter logic [15:0] DB_CYCLES = DEF_DB_CYCLES
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run_i,
  input  logic          step_i,
  input  logic          clr_i,
  input  logic          loop_i,
  input  logic [AW-1:0] start_addr_i,
  input  logic [AW-1:0] end_addr_i,
  input  logic          div_tick_i,
  output logic          div_on_o,
  output logic [AW-1:0] addr_o,
  output logic          addr_vld_o,
  output logic          busy_o,
  output logic          done_o
);

  state_t        r_state;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_start;
  logic [AW-1:0] r_end;
  logic          r_addr_vld;
  logic          r_div_on;
  logic          r_busy;
  logic          r_done;
  logic          r_tick_q;

  logic          w_tick_rise;
  logic          w_step_rise;
  logic          w_adv;
  logic          w_at_end;

  // The divided clock is sampled as data; only its rising edge matters.
  assign w_tick_rise = div_tick_i & ~r_tick_q;

`ifdef STEP_DEBOUNCE_EN
  btn_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_step_db (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn  (step_i),
    .o_rise (w_step_rise)
  );
`else
  logic r_step_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step_q <= 1'b0;
    end else begin
      r_step_q <= step_i;
    end
  end

  assign w_step_rise = step_i & ~r_step_q;
`endif

  assign w_adv    = (r_state == ST_RUN) ? w_tick_rise : w_step_rise;
  assign w_at_end = (r_addr == r_end);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_start    <= '0;
      r_end      <= '0;
      r_addr_vld <= 1'b0;
      r_div_on   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_tick_q   <= 1'b0;
    end else begin
      r_tick_q   <= div_tick_i;
      r_addr_vld <= 1'b0;
      if (clr_i) begin
        r_state  <= ST_IDLE;
        r_div_on <= 1'b0;
        r_busy   <= 1'b0;
        r_done   <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (run_i || w_step_rise) begin
              r_start    <= start_addr_i;
              r_end      <= end_addr_i;
              r_addr     <= start_addr_i;
              r_addr_vld <= 1'b1;
              r_busy     <= 1'b1;
              r_state    <= run_i ? ST_RUN : ST_PAUSE;
              r_div_on   <= run_i;
            end
          end
          ST_RUN, ST_PAUSE: begin
            if (w_adv && w_at_end && !loop_i) begin
              r_state  <= ST_DONE;
              r_done   <= 1'b1;
              r_busy   <= 1'b0;
              r_div_on <= 1'b0;
            end else begin
              // An advance and a mode change in the same cycle both take effect.
              if (w_adv) begin
                r_addr     <= w_at_end ? r_start : r_addr + AW'(1);
                r_addr_vld <= 1'b1;
              end
              r_state  <= run_i ? ST_RUN : ST_PAUSE;
              r_div_on <= run_i;
            end
          end
          ST_DONE: begin
            r_state <= ST_DONE;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign addr_o     = r_addr;
  assign addr_vld_o = r_addr_vld;
  assign div_on_o   = r_div_on;
  assign busy_o     = r_busy;
  assign done_o     = r_done;

endmodule

// File: tb/tb_rom_seq_ctrl.sv
// Directed bench for rom_seq_ctrl with a behavioural divider model.
// With STEP_DEBOUNCE_EN the step tests use the debounced path (DB_CYCLES=10).
`timescale 1ns/1ps
module tb_rom_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run_i = 1'b0;
  logic       step_i = 1'b0;
  logic       clr_i = 1'b0;
  logic       loop_i = 1'b0;
  logic [7:0] start_addr_i = 8'h00;
  logic [7:0] end_addr_i = 8'h00;
  logic       div_tick_i;
  logic       div_on_o;
  logic [7:0] addr_o;
  logic       addr_vld_o;
  logic       busy_o;
  logic       done_o;

  int errors = 0;
  int checks = 0;

  logic [1:0] dcnt;

  always #5 clk = ~clk;

  // Divider model: output toggles every 4 cycles while enabled, cleared when off.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt       <= 2'd0;
      div_tick_i <= 1'b0;
    end else if (!div_on_o) begin
      dcnt       <= 2'd0;
      div_tick_i <= 1'b0;
    end else if (dcnt == 2'd3) begin
      dcnt       <= 2'd0;
      div_tick_i <= ~div_tick_i;
    end else begin
      dcnt <= dcnt + 2'd1;
    end
  end

  rom_seq_ctrl #(
    .AW (8)
`ifdef STEP_DEBOUNCE_EN
    ,
    .DB_CYCLES (16'd10)
`endif
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run_i        (run_i),
    .step_i       (step_i),
    .clr_i        (clr_i),
    .loop_i       (loop_i),
    .start_addr_i (start_addr_i),
    .end_addr_i   (end_addr_i),
    .div_tick_i   (div_tick_i),
    .div_on_o     (div_on_o),
    .addr_o       (addr_o),
    .addr_vld_o   (addr_vld_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    run_i  = 1'b0;
    step_i = 1'b0;
    clr_i  = 1'b1;
    tick();
    clr_i = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({div_on_o, addr_vld_o, busy_o, done_o, addr_o} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: got on=%b vld=%b busy=%b done=%b addr=%h, expected all 0",
               div_on_o, addr_vld_o, busy_o, done_o, addr_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    $display("test_reset: done");
  endtask

  task automatic test_run_stop();
    logic [7:0] ev_addr [8];
    int         ev_cyc  [8];
    int         n;
    int         vld_after;
    n = 0;
    go_idle();
    start_addr_i = 8'd3;
    end_addr_i   = 8'd5;
    loop_i       = 1'b0;
    run_i        = 1'b1;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      tick();
      if (addr_vld_o === 1'b1 && n < 8) begin
        ev_addr[n] = addr_o;
        ev_cyc[n]  = cyc;
        n++;
      end
      if (cyc == 1) begin
        checks++;
        if ({addr_vld_o, div_on_o, busy_o, addr_o} !== {3'b111, 8'd3}) begin
          errors++;
          $display("FAIL run_start: got vld=%b on=%b busy=%b addr=%h, expected 1 1 1 03",
                   addr_vld_o, div_on_o, busy_o, addr_o);
        end
      end
      if (done_o === 1'b1) break;
    end
    checks++;
    if (n !== 3 || ev_addr[1] !== 8'd4 || ev_addr[2] !== 8'd5) begin
      errors++;
      $display("FAIL run_stop_seq: got %0d pulses (addr1=%h addr2=%h), expected 3 pulses 03,04,05",
               n, ev_addr[1], ev_addr[2]);
    end
    checks++;
    if (n == 3 && (ev_cyc[2] - ev_cyc[1]) !== 8) begin
      errors++;
      $display("FAIL run_stop_spacing: got %0d cycles between pulses, expected 8",
               ev_cyc[2] - ev_cyc[1]);
    end
    checks++;
    if ({done_o, div_on_o, busy_o, addr_o} !== {3'b100, 8'd5}) begin
      errors++;
      $display("FAIL run_stop_done: got done=%b on=%b busy=%b addr=%h, expected 1 0 0 05",
               done_o, div_on_o, busy_o, addr_o);
    end
    vld_after = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (addr_vld_o === 1'b1) vld_after++;
    end
    checks++;
    if (done_o !== 1'b1 || addr_o !== 8'd5 || vld_after !== 0) begin
      errors++;
      $display("FAIL done_hold: got done=%b addr=%h pulses=%0d, expected 1 05 0",
               done_o, addr_o, vld_after);
    end
    $display("test_run_stop: pulses=%0d final addr=%h", n, addr_o);
  endtask

  task automatic test_run_loop();
    logic [7:0] exp_a [5];
    logic [7:0] ev_addr [5];
    int         ev_cyc  [5];
    int         n;
    int         bad_busy;
    int         bad_gap;
    exp_a    = '{8'd3, 8'd4, 8'd5, 8'd3, 8'd4};
    n        = 0;
    bad_busy = 0;
    bad_gap  = 0;
    go_idle();
    start_addr_i = 8'd3;
    end_addr_i   = 8'd5;
    loop_i       = 1'b1;
    run_i        = 1'b1;
    for (int cyc = 1; cyc <= 200 && n < 5; cyc++) begin
      tick();
      if (busy_o !== 1'b1 || done_o !== 1'b0) bad_busy++;
      if (addr_vld_o === 1'b1) begin
        ev_addr[n] = addr_o;
        ev_cyc[n]  = cyc;
        n++;
      end
    end
    checks++;
    if (n !== 5) begin
      errors++;
      $display("FAIL loop_count: got %0d pulses, expected 5", n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (ev_addr[i] !== exp_a[i]) begin
        errors++;
        $display("FAIL loop_addr[%0d]: got %h expected %h", i, ev_addr[i], exp_a[i]);
      end
      if (i >= 2 && (ev_cyc[i] - ev_cyc[i-1]) != 8) bad_gap++;
    end
    checks++;
    if (bad_busy !== 0 || bad_gap !== 0) begin
      errors++;
      $display("FAIL loop_busy_spacing: got %0d bad busy/done cycles and %0d bad gaps, expected 0 and 0",
               bad_busy, bad_gap);
    end
    loop_i = 1'b0;
    $display("test_run_loop: pulses=%0d", n);
  endtask

  task automatic test_step_wrap();
    logic [7:0] exp_s [4];
    exp_s = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    go_idle();
    start_addr_i = 8'hFE;
    end_addr_i   = 8'h01;
    loop_i       = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step_i = 1'b1;
      tick();
      checks++;
      if ({addr_vld_o, busy_o, div_on_o, addr_o} !== {3'b110, exp_s[i]}) begin
        errors++;
        $display("FAIL step_wrap[%0d]: got vld=%b busy=%b on=%b addr=%h, expected 1 1 0 %h",
                 i, addr_vld_o, busy_o, div_on_o, addr_o, exp_s[i]);
      end
      step_i = 1'b0;
      tick();
    end
    step_i = 1'b1;
    tick();
    checks++;
    if ({done_o, busy_o, addr_vld_o, addr_o} !== {3'b100, 8'h01}) begin
      errors++;
      $display("FAIL step_end_done: got done=%b busy=%b vld=%b addr=%h, expected 1 0 0 01",
               done_o, busy_o, addr_vld_o, addr_o);
    end
    step_i = 1'b0;
    tick();
    $display("test_step_wrap: final addr=%h done=%b", addr_o, done_o);
  endtask

  task automatic test_tick_and_pause();
    logic       prev;
    logic       found;
    logic [7:0] a0;
    int         vld_cnt;
    int         wait_cyc;
    found = 1'b0;
    a0    = 8'h00;
    go_idle();
    start_addr_i = 8'd10;
    end_addr_i   = 8'd20;
    run_i        = 1'b1;
    tick();
    prev = div_tick_i;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (div_tick_i === 1'b1 && prev === 1'b0) begin
        found = 1'b1;
        break;
      end
      prev = div_tick_i;
    end
    // The divided clock just rose: drop run_i inside that same cycle.
    a0    = addr_o;
    run_i = 1'b0;
    tick();
    checks++;
    if (found !== 1'b1 || addr_o !== a0 + 8'd1 || addr_vld_o !== 1'b1 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL tick_with_pause: got found=%b addr=%h vld=%b busy=%b, expected 1 %h 1 1",
               found, addr_o, addr_vld_o, busy_o, a0 + 8'd1);
    end
    checks++;
    if (div_on_o !== 1'b0) begin
      errors++;
      $display("FAIL pause_div_off: got div_on=%b expected 0", div_on_o);
    end
    a0      = addr_o;
    vld_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (addr_vld_o === 1'b1) vld_cnt++;
    end
    checks++;
    if (vld_cnt !== 0 || addr_o !== a0) begin
      errors++;
      $display("FAIL pause_hold: got %0d pulses addr=%h, expected 0 and %h", vld_cnt, addr_o, a0);
    end
    run_i = 1'b1;
    tick();
    checks++;
    if (div_on_o !== 1'b1 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL resume_div_on: got div_on=%b busy=%b expected 1 1", div_on_o, busy_o);
    end
    // Divider restarts from zero: rise after 4 more edges, advance on the 5th.
    wait_cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (addr_vld_o === 1'b1) begin
        wait_cyc = i;
        break;
      end
    end
    checks++;
    if (wait_cyc !== 5 || addr_o !== a0 + 8'd1) begin
      errors++;
      $display("FAIL resume_latency: got advance after %0d cycles addr=%h, expected 5 and %h",
               wait_cyc, addr_o, a0 + 8'd1);
    end
    $display("test_tick_and_pause: addr=%h", addr_o);
  endtask

  task automatic test_clr_and_reset();
    logic found;
    found = 1'b0;
    go_idle();
    start_addr_i = 8'd3;
    end_addr_i   = 8'd9;
    loop_i       = 1'b0;
    run_i        = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (addr_vld_o === 1'b1 && addr_o === 8'd4) begin
        found = 1'b1;
        break;
      end
    end
    clr_i = 1'b1;
    run_i = 1'b0;
    tick();
    clr_i = 1'b0;
    checks++;
    if (found !== 1'b1 || {busy_o, done_o, div_on_o, addr_o} !== {3'b000, 8'd4}) begin
      errors++;
      $display("FAIL clr_in_run: got found=%b busy=%b done=%b on=%b addr=%h, expected 1 0 0 0 04",
               found, busy_o, done_o, div_on_o, addr_o);
    end
    tick();
    tick();
    checks++;
    if (addr_o !== 8'd4 || busy_o !== 1'b0 || addr_vld_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: got addr=%h busy=%b vld=%b, expected 04 0 0", addr_o, busy_o, addr_vld_o);
    end
    run_i = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    // Asynchronous reset applied mid-cycle, checked before any clock edge.
    rst_n = 1'b0;
    #1;
    checks++;
    if ({div_on_o, addr_vld_o, busy_o, done_o, addr_o} !== 12'h000) begin
      errors++;
      $display("FAIL async_reset: got on=%b vld=%b busy=%b done=%b addr=%h, expected all 0",
               div_on_o, addr_vld_o, busy_o, done_o, addr_o);
    end
    run_i = 1'b0;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    $display("test_clr_and_reset: done");
  endtask

`ifdef STEP_DEBOUNCE_EN
  task automatic test_debounce();
    int vld_at;
    int vld_cnt;
    go_idle();
    start_addr_i = 8'h20;
    end_addr_i   = 8'h30;
    // Long press: first sampled at edge 1, advance 12 edges after that sample.
    vld_at  = 0;
    vld_cnt = 0;
    step_i  = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 21) step_i = 1'b0;
      tick();
      if (addr_vld_o === 1'b1) begin
        vld_cnt++;
        vld_at = k;
      end
    end
    checks++;
    if (vld_cnt !== 1 || vld_at !== 13 || addr_o !== 8'h20) begin
      errors++;
      $display("FAIL db_press: got %0d pulses at edge %0d addr=%h, expected 1 at 13 addr 20",
               vld_cnt, vld_at, addr_o);
    end
    vld_cnt = 0;
    step_i  = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 6) step_i = 1'b0;
      tick();
      if (addr_vld_o === 1'b1) vld_cnt++;
    end
    checks++;
    if (vld_cnt !== 0 || addr_o !== 8'h20) begin
      errors++;
      $display("FAIL db_glitch: got %0d pulses addr=%h, expected 0 and 20", vld_cnt, addr_o);
    end
    vld_at  = 0;
    vld_cnt = 0;
    step_i  = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 21) step_i = 1'b0;
      tick();
      if (addr_vld_o === 1'b1) begin
        vld_cnt++;
        vld_at = k;
      end
    end
    checks++;
    if (vld_cnt !== 1 || vld_at !== 13 || addr_o !== 8'h21) begin
      errors++;
      $display("FAIL db_advance: got %0d pulses at edge %0d addr=%h, expected 1 at 13 addr 21",
               vld_cnt, vld_at, addr_o);
    end
    $display("test_debounce: addr=%h", addr_o);
  endtask
`endif

  initial begin
    test_reset();
    test_run_stop();
    test_run_loop();
`ifdef STEP_DEBOUNCE_EN
    test_debounce();
`else
    test_step_wrap();
`endif
    test_tick_and_pause();
    test_clr_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
